// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - decode/forwarding/EX-operand bundle for the ID/EX operand stage
interface id_ex_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
);
    logic              id_valid;
    logic [31:0]       id_instr;
    logic              id_reg_write;
    logic              id_alu_src;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              id_branch;
    logic [1:0]        id_alu_op;
    logic              ex_hold;
    logic              flush;
    logic              exmem_reg_write;
    logic [RA_W-1:0]   exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              wb_we;
    logic [RA_W-1:0]   wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              id_stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_A;
    logic [DATA_W-1:0] ex_B;
    logic [DATA_W-1:0] ex_store_data;
    logic [1:0]        ex_alu_op;
    logic [5:0]        ex_funct;
    logic [RA_W-1:0]   ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              ex_branch;
    logic [DATA_W-1:0] ex_imm;

    modport master (
        output id_valid, id_instr, id_reg_write, id_alu_src, id_mem_read, id_mem_write,
               id_mem_to_reg, id_branch, id_alu_op, ex_hold, flush,
               exmem_reg_write, exmem_rd, exmem_result, wb_we, wb_waddr, wb_wdata,
        input  id_stall, ex_valid, ex_A, ex_B, ex_store_data, ex_alu_op, ex_funct, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_imm
    );

    modport slave (
        input  id_valid, id_instr, id_reg_write, id_alu_src, id_mem_read, id_mem_write,
               id_mem_to_reg, id_branch, id_alu_op, ex_hold, flush,
               exmem_reg_write, exmem_rd, exmem_result, wb_we, wb_waddr, wb_wdata,
        output id_stall, ex_valid, ex_A, ex_B, ex_store_data, ex_alu_op, ex_funct, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_imm
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - register file, load-use hazard, ID/EX register and operand forwarding
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    id_ex_operand_stage_if.slave bus
);
    localparam int NREG = 1 << RA_W;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic [1:0]        alu_op;
        logic [5:0]        funct;
        logic [RA_W-1:0]   rs;
        logic [RA_W-1:0]   rt;
        logic [RA_W-1:0]   rd;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
    } idex_t;

    logic [DATA_W-1:0] rf [NREG];

    logic [5:0]        opcode;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              hz;
    idex_t             dec;
    idex_t             ex_q;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    assign opcode = bus.id_instr[31:26];
    assign rs     = bus.id_instr[25:21];
    assign rt     = bus.id_instr[20:16];

    // Same-cycle writeback is bypassed so the value captured into ID/EX is never stale.
    always_comb begin
        rs_val = rf[rs];
        if (rs == '0)
            rs_val = '0;
        else if (bus.wb_we && bus.wb_waddr == rs)
            rs_val = bus.wb_wdata;
    end

    always_comb begin
        rt_val = rf[rt];
        if (rt == '0)
            rt_val = '0;
        else if (bus.wb_we && bus.wb_waddr == rt)
            rt_val = bus.wb_wdata;
    end

    assign hz = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                ((ex_q.rd == rs) || (ex_q.rd == rt));

    assign bus.id_stall = bus.ex_hold || (hz && !bus.flush);

    always_comb begin
        dec            = '0;
        dec.valid      = bus.id_valid;
        dec.reg_write  = bus.id_reg_write;
        dec.alu_src    = bus.id_alu_src;
        dec.mem_read   = bus.id_mem_read;
        dec.mem_write  = bus.id_mem_write;
        dec.mem_to_reg = bus.id_mem_to_reg;
        dec.branch     = bus.id_branch;
        dec.alu_op     = bus.id_alu_op;
        dec.funct      = bus.id_instr[5:0];
        dec.rs         = rs;
        dec.rt         = rt;
        dec.rd         = (opcode == 6'd0) ? bus.id_instr[15:11] : rt;
        dec.rs_val     = rs_val;
        dec.rt_val     = rt_val;
        dec.imm        = {{(DATA_W-16){bus.id_instr[15]}}, bus.id_instr[15:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rf <= '{default: '0};
        else if (bus.wb_we && bus.wb_waddr != '0)
            rf[bus.wb_waddr] <= bus.wb_wdata;
    end

    // A bubble is the all-zero slot, identical to the reset contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ex_q <= '0;
        else if (!bus.ex_hold) begin
            if (bus.flush || hz)
                ex_q <= '0;
            else
                ex_q <= dec;
        end
    end

    always_comb begin
        fwd_rs = ex_q.rs_val;
        if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == ex_q.rs)
            fwd_rs = bus.exmem_result;
        else if (bus.wb_we && bus.wb_waddr != '0 && bus.wb_waddr == ex_q.rs)
            fwd_rs = bus.wb_wdata;
    end

    always_comb begin
        fwd_rt = ex_q.rt_val;
        if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == ex_q.rt)
            fwd_rt = bus.exmem_result;
        else if (bus.wb_we && bus.wb_waddr != '0 && bus.wb_waddr == ex_q.rt)
            fwd_rt = bus.wb_wdata;
    end

    assign bus.ex_A          = fwd_rs;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_B          = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_funct      = ex_q.funct;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_imm        = ex_q.imm;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed and randomized checks of id_ex_operand_stage against a reference model
module tb_id_ex_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] rnd;

    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.DATA_W(32), .RA_W(5)) bus ();

    id_ex_operand_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: architectural register file plus the contents of the EX slot.
    logic [31:0] m_rf [32];
    logic        m_v, m_rw, m_as, m_mr, m_mw, m_m2r, m_br;
    logic [1:0]  m_aop;
    logic [5:0]  m_fn;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rsv, m_rtv, m_imm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_clear_ex();
        {m_v, m_rw, m_as, m_mr, m_mw, m_m2r, m_br} = '0;
        m_aop = 0; m_fn = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_rsv = 0; m_rtv = 0; m_imm = 0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        m_clear_ex();
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 0;
        if (bus.wb_we && bus.wb_waddr == a) return bus.wb_wdata;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] v);
        if (bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == a) return bus.exmem_result;
        if (bus.wb_we && bus.wb_waddr != 0 && bus.wb_waddr == a) return bus.wb_wdata;
        return v;
    endfunction

    // Called at a negedge with inputs applied: check every output, advance the model, cross one posedge.
    task automatic cycle();
        logic [4:0]  rs_i, rt_i;
        logic        hz;
        logic [31:0] sd;
        #1;
        rs_i = bus.id_instr[25:21];
        rt_i = bus.id_instr[20:16];
        hz = bus.id_valid && m_v && m_mr && m_rd != 0 && (m_rd == rs_i || m_rd == rt_i);
        sd = m_fwd(m_rt, m_rtv);
        chk("id_stall", 32'(bus.id_stall), 32'(bus.ex_hold | (hz & ~bus.flush)));
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_v));
        chk("ex_A", bus.ex_A, m_fwd(m_rs, m_rsv));
        chk("ex_store_data", bus.ex_store_data, sd);
        chk("ex_B", bus.ex_B, m_as ? m_imm : sd);
        chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(m_aop));
        chk("ex_funct", 32'(bus.ex_funct), 32'(m_fn));
        chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
        chk("ex_ctrl", {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_branch},
            {27'd0, m_rw, m_mr, m_mw, m_m2r, m_br});
        chk("ex_imm", bus.ex_imm, m_imm);
        if (!bus.ex_hold) begin
            if (bus.flush || hz) m_clear_ex();
            else begin
                m_v = bus.id_valid; m_rw = bus.id_reg_write; m_as = bus.id_alu_src;
                m_mr = bus.id_mem_read; m_mw = bus.id_mem_write; m_m2r = bus.id_mem_to_reg;
                m_br = bus.id_branch; m_aop = bus.id_alu_op; m_fn = bus.id_instr[5:0];
                m_rs = rs_i; m_rt = rt_i;
                m_rd = (bus.id_instr[31:26] == 0) ? bus.id_instr[15:11] : rt_i;
                m_rsv = m_read(rs_i); m_rtv = m_read(rt_i);
                m_imm = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
            end
        end
        if (bus.wb_we && bus.wb_waddr != 0) m_rf[bus.wb_waddr] = bus.wb_wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_instr = 0;
        {bus.id_reg_write, bus.id_alu_src, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg, bus.id_branch} = '0;
        bus.id_alu_op = 0; bus.ex_hold = 0; bus.flush = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.wb_we = 0; bus.wb_waddr = 0; bus.wb_wdata = 0;
    endtask

    task automatic dec(input logic [31:0] instr, input logic [5:0] ctl, input logic [1:0] aop);
        bus.id_valid = 1; bus.id_instr = instr;
        {bus.id_reg_write, bus.id_alu_src, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg, bus.id_branch} = ctl;
        bus.id_alu_op = aop;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we = 1; bus.wb_waddr = a; bus.wb_wdata = d;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // ctl bits: {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch}
    localparam logic [5:0] C_RTYPE = 6'b100000;
    localparam logic [5:0] C_LW    = 6'b111010;
    localparam logic [5:0] C_SW    = 6'b010100;

    initial begin
        idle();
        m_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_ex_valid", 32'(bus.ex_valid), 0);
        chk("reset_ex_A", bus.ex_A, 0);
        chk("reset_id_stall", 32'(bus.id_stall), 0);
        @(negedge clk);
        rst = 0;

        // r0 is never written
        idle(); wb(5'd0, 32'hDEAD); dec(rtype(5'd0, 5'd0, 5'd3, 6'h20), C_RTYPE, 2'b10);
        cycle();
        idle(); dec(rtype(5'd0, 5'd0, 5'd3, 6'h20), C_RTYPE, 2'b10);
        #1 chk("r0_write_ignored_A", bus.ex_A, 0);
        cycle();
        idle();
        #1 chk("r0_read_zero_B", bus.ex_B, 0);

        // same-cycle write-through bypass into the captured operands
        wb(5'd7, 32'h1234); dec(rtype(5'd7, 5'd7, 5'd3, 6'h20), C_RTYPE, 2'b10);
        cycle();
        idle();
        #1;
        chk("bypass_A", bus.ex_A, 32'h1234);
        chk("bypass_B", bus.ex_B, 32'h1234);
        chk("bypass_funct", 32'(bus.ex_funct), 32'h20);

        // EX/MEM forward beats MEM/WB forward
        dec(rtype(5'd4, 5'd0, 5'd3, 6'h20), C_RTYPE, 2'b10);
        cycle();
        idle();
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd4; bus.exmem_result = 32'hAAAA;
        wb(5'd4, 32'hBBBB);
        #1 chk("fwd_exmem_priority", bus.ex_A, 32'hAAAA);
        bus.exmem_reg_write = 0;
        #1 chk("fwd_memwb", bus.ex_A, 32'hBBBB);
        cycle();

        // load-use: one bubble, then MEM/WB forward of load data
        idle(); wb(5'd1, 32'h100); dec(itype(6'h23, 5'd1, 5'd2, 16'd0), C_LW, 2'b00);
        cycle();
        idle(); dec(rtype(5'd2, 5'd1, 5'd3, 6'h20), C_RTYPE, 2'b10);
        #1 chk("loaduse_stall", 32'(bus.id_stall), 1);
        cycle();
        #1;
        chk("loaduse_bubble", 32'(bus.ex_valid), 0);
        chk("loaduse_stall_released", 32'(bus.id_stall), 0);
        cycle();
        idle(); wb(5'd2, 32'hCAFE);
        #1;
        chk("loaduse_dep_valid", 32'(bus.ex_valid), 1);
        chk("loaduse_fwd_A", bus.ex_A, 32'hCAFE);
        chk("loaduse_B_r1", bus.ex_B, 32'h100);
        cycle();

        // sw: sign-extended immediate on B, rt on store data
        idle(); wb(5'd5, 32'h77); dec(itype(6'h2b, 5'd6, 5'd5, 16'hFFFC), C_SW, 2'b00);
        cycle();
        idle();
        #1;
        chk("sw_B_imm", bus.ex_B, 32'hFFFF_FFFC);
        chk("sw_store_data", bus.ex_store_data, 32'h77);
        chk("sw_mem_write", 32'(bus.ex_mem_write), 1);

        dec(rtype(5'd1, 5'd2, 5'd9, 6'h22), C_RTYPE, 2'b10);
        cycle();
        idle();
        #1 chk("rtype_rd", 32'(bus.ex_rd), 9);

        // hold wins over flush; flush taken once hold drops
        for (int k = 0; k < 2; k++) begin
            idle(); bus.ex_hold = 1; bus.flush = 1; dec(rtype(5'd3, 5'd4, 5'd11, 6'h24), C_RTYPE, 2'b10);
            #1 chk("hold_stall", 32'(bus.id_stall), 1);
            cycle();
            #1;
            chk("hold_rd", 32'(bus.ex_rd), 9);
            chk("hold_valid", 32'(bus.ex_valid), 1);
        end
        bus.ex_hold = 0;
        cycle();
        #1;
        chk("flush_bubble_valid", 32'(bus.ex_valid), 0);
        chk("flush_bubble_rd", 32'(bus.ex_rd), 0);

        // flush together with a load-use hazard: bubble without stall
        idle(); dec(itype(6'h23, 5'd1, 5'd2, 16'd4), C_LW, 2'b00);
        cycle();
        idle(); bus.flush = 1; dec(rtype(5'd2, 5'd1, 5'd3, 6'h20), C_RTYPE, 2'b10);
        #1 chk("flush_hz_no_stall", 32'(bus.id_stall), 0);
        cycle();
        idle();
        #1 chk("flush_hz_bubble", 32'(bus.ex_valid), 0);

        for (int n = 0; n < 300; n++) begin
            rnd = $urandom;
            rnd[25:21] = 5'($urandom_range(0, 7));
            rnd[20:16] = 5'($urandom_range(0, 7));
            rnd[15:11] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) rnd[31:26] = 6'd0;
            bus.id_instr = rnd;
            bus.id_valid = ($urandom_range(0, 7) != 0);
            bus.id_reg_write = 1'($urandom);
            bus.id_alu_src = 1'($urandom);
            bus.id_mem_read = ($urandom_range(0, 2) == 0);
            bus.id_mem_write = 1'($urandom);
            bus.id_mem_to_reg = 1'($urandom);
            bus.id_branch = 1'($urandom);
            bus.id_alu_op = 2'($urandom);
            bus.ex_hold = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.exmem_reg_write = 1'($urandom);
            bus.exmem_rd = 5'($urandom_range(0, 7));
            bus.exmem_result = $urandom;
            bus.wb_we = 1'($urandom);
            bus.wb_waddr = 5'($urandom_range(0, 7));
            bus.wb_wdata = $urandom;
            cycle();
        end

        // asynchronous reset in the middle of a hold
        idle(); wb(5'd5, 32'h55); dec(itype(6'h23, 5'd1, 5'd2, 16'd8), C_LW, 2'b00);
        cycle();
        idle(); bus.ex_hold = 1;
        #2 rst = 1;
        #1;
        chk("async_rst_valid", 32'(bus.ex_valid), 0);
        chk("async_rst_ctrl", {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_branch}, 0);
        chk("async_rst_stall", 32'(bus.id_stall), 1);
        m_reset();
        @(negedge clk);
        rst = 0;
        idle(); dec(rtype(5'd5, 5'd0, 5'd3, 6'h20), C_RTYPE, 2'b10);
        cycle();
        idle();
        #1;
        chk("post_rst_r5", bus.ex_A, 0);
        chk("post_rst_valid", 32'(bus.ex_valid), 1);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Decode-to-execute operand stage of the pipelined MIPS core. Holds the 32x32 register file, sign-extends the immediate, and latches decoded operands and control into the ID/EX pipeline register. It drives the ALU's `A`/`B` operands after EX/MEM and MEM/WB forwarding, and passes `ALUOp`/`funct` to the ALU control decoder. It also detects load-use hazards and inserts bubbles.

## Interface
- `DATA_W`, 32, datapath width.
- `RA_W`, 5, register address width; register file depth is 2^RA_W.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: `id_instr` holds a real instruction.
- `id_instr` in 32: instruction in decode.
- `id_reg_write`, `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_branch` in 1 each: control-unit outputs for `id_instr`.
- `id_alu_op` in 2: control-unit ALUOp.
- `ex_hold` in 1: downstream stall; freeze the ID/EX register.
- `flush` in 1: kill the instruction in decode (branch taken).
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forwarding source.
- `wb_we` in 1, `wb_waddr` in 5, `wb_wdata` in 32: register-file write port and MEM/WB forwarding source.
- `id_stall` out 1: hold PC and IF/ID this cycle.
- `ex_valid` out 1: the ID/EX slot holds a live instruction.
- `ex_A`, `ex_B` out 32: forwarded ALU operands.
- `ex_store_data` out 32: forwarded rt value, used as sw data.
- `ex_alu_op` out 2, `ex_funct` out 6: inputs to ALU control.
- `ex_rd` out 5: destination register (already resolved by RegDst).
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch` out 1 each: latched control.
- `ex_imm` out 32: sign-extended immediate, used for the branch target.

## Operation
**Decode fields**
- `rs`=instr[25:21], `rt`=instr[20:16], `funct`=instr[5:0].
- `imm` = sign-extended instr[15:0].
- `dest` = instr[15:11] if opcode instr[31:26]==0, else `rt`.

**Register file**
- Two combinational read ports (`rs`, `rt`) and one write port at posedge when `wb_we` and `wb_waddr`!=0.
- Register 0 always reads 0 and is never written.
- Write-through bypass: if `wb_we` and `wb_waddr`==read address and the address is !=0, the read returns `wb_wdata` in the same cycle.

**Load-use hazard**
- `hz` = `id_valid` & `ex_valid` & `ex_mem_read` & `ex_rd`!=0 & (`ex_rd`==`rs` | `ex_rd`==`rt`).

**ID/EX register update, in priority order**
1. `ex_hold`: all ID/EX state holds.
2. `flush`: load a bubble.
3. `hz`: load a bubble.
4. Otherwise: load decoded values, with `ex_valid`=`id_valid`.

**Bubble definition**
- `ex_valid`=0 and all control outputs=0.
- Data fields are don't-care, but are cleared to 0.

**id_stall and flush acceptance**
- `id_stall` = `ex_hold` | (`hz` & ~`flush`).
- `flush` is only accepted when `ex_hold`=0; upstream keeps `flush` asserted until it is accepted.

**Forwarding (combinational, per EX source rs/rt)**
- If `exmem_reg_write` & `exmem_rd`!=0 & `exmem_rd`==src: use `exmem_result`.
- Else if `wb_we` & `wb_waddr`!=0 & `wb_waddr`==src: use `wb_wdata`.
- Else use the latched register value.
- EX/MEM has priority over MEM/WB.

**Operand drive**
- `ex_A` = forwarded rs.
- `ex_store_data` = forwarded rt.
- `ex_B` = `ex_alu_src` ? `ex_imm` : forwarded rt. `ex_alu_src` is internal latched state.

## Timing
- On `rst`, asynchronously:
  - ID/EX register cleared: `ex_valid`=0, all `ex_*` controls=0, `ex_rd`=0, `ex_funct`=0, `ex_alu_op`=0, `ex_imm`=0.
  - Register file cleared to 0.
  - Consequently `ex_A`=`ex_B`=`ex_store_data`=0 unless forwarding inputs are active.
  - `id_stall` follows its combinational equation; with `ex_valid`=0 it equals `ex_hold`.
- Latency: decode to EX outputs is 1 cycle.
- Forward and bypass paths are zero-cycle combinational.
- Register write lands at the same edge the ID/EX register captures, so a same-cycle write is bypassed into the captured value.
- A load followed immediately by a dependent instruction gives exactly 1 bubble cycle. The dependent instruction then receives load data through the MEM/WB forward.
- Simultaneous events:
  - `flush` & `hz`: bubble, `id_stall`=0.
  - `ex_hold` & anything: freeze, `id_stall`=1.
- `rst` mid-stall: state clears immediately. After release, the pipeline resumes with an empty EX slot.

## Test plan
- Reset:
  - Assert `rst` asynchronously mid-cycle → `ex_valid`=0 and all controls 0 immediately.
  - Then read r5 → 0.
- Register 0 and bypass:
  - Write r0 with 0xDEAD → r0 reads 0.
  - Write r7=0x1234 while decoding `add r3,r7,r7` in the same cycle → next cycle `ex_A`=`ex_B`=0x1234.
- Forwarding priority:
  - EX has rs=r4; `exmem_rd`=4 with 0xAAAA and `wb_waddr`=4 with 0xBBBB, both enabled → `ex_A`=0xAAAA.
  - Drop `exmem_reg_write` → `ex_A`=0xBBBB.
- Load-use:
  - Issue `lw r2,0(r1)` then `add r3,r2,r1` → one cycle with `id_stall`=1 and a bubble (`ex_valid`=0).
  - Then `add` in EX with `ex_A`=`wb_wdata` forwarded.
- Immediate:
  - `sw` with imm 0xFFFC and `alu_src`=1 → `ex_B`=0xFFFFFFFC and `ex_store_data`=rt value.
  - R-type with rd=9 → `ex_rd`=9.
- Hold versus flush:
  - `ex_hold`=1 with `flush`=1 for 2 cycles → EX outputs unchanged and `id_stall`=1.
  - Release hold with `flush` still 1 → bubble loaded.
